// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding and
// default widths.
package pipe_ctrl_pkg;

    localparam int REGBITS_DEF = 4;
    localparam int CNTBITS_DEF = 16;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        FLUSH   = 2'd2,
        MEMWAIT = 2'd3
    } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; async active-low clear.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipe: load-use stalls, branch flushes and
// memory freezes, with saturating stall/flush counters for performance debug.
//
// state   | meaning
// RUN     | normal issue; evaluates memBusy_M > redirect_E > loadUse
// LDSTALL | second bubble of a load-use stall; PC/FD held
// FLUSH   | second squash cycle after a redirect (instr-mem read latency)
// MEMWAIT | data memory busy; whole pipe frozen, one-cycle resume penalty
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REGBITS = REGBITS_DEF,
    parameter int CNTBITS = CNTBITS_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [REGBITS-1:0] src1Index_D,
    input  logic [REGBITS-1:0] src2Index_D,
    input  logic               src1Used_D,
    input  logic               src2Used_D,
    input  logic [REGBITS-1:0] destIndex_E,
    input  logic               regWrtEn_E,
    input  logic               memRead_E,
    input  logic               noop_E,
    input  logic               redirect_E,
    input  logic               memBusy_M,
    output logic               pcWrtEn,
    output logic               fdWrtEn,
    output logic               deWrtEn,
    output logic               fdNoop,
    output logic               deNoop,
    output logic [1:0]         state,
    output logic [CNTBITS-1:0] stallCnt,
    output logic [CNTBITS-1:0] flushCnt
);

    hz_state_t state_q, state_d;
    logic      load_use;
    logic      flush_inc;

    // Register 0 is deliberately not exempt: the bench/core may use it as a real register.
    assign load_use = memRead_E & regWrtEn_E & ~noop_E &
                      ((src1Used_D & (src1Index_D == destIndex_E)) |
                       (src2Used_D & (src2Index_D == destIndex_E)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pcWrtEn   = 1'b0;
        fdWrtEn   = 1'b0;
        deWrtEn   = 1'b0;
        fdNoop    = 1'b0;
        deNoop    = 1'b0;
        flush_inc = 1'b0;

        if (!reset) begin
            fdNoop = 1'b1;
            deNoop = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (memBusy_M) begin
                        state_d = MEMWAIT;
                    end else if (redirect_E && !noop_E) begin
                        {pcWrtEn, fdWrtEn, deWrtEn} = 3'b111;
                        {fdNoop, deNoop}            = 2'b11;
                        flush_inc                   = 1'b1;
                        state_d                     = FLUSH;
                    end else if (load_use) begin
                        deWrtEn = 1'b1;
                        deNoop  = 1'b1;
                        state_d = LDSTALL;
                    end else begin
                        {pcWrtEn, fdWrtEn, deWrtEn} = 3'b111;
                    end
                end
                LDSTALL: begin
                    if (!memBusy_M) begin
                        deWrtEn = 1'b1;
                        deNoop  = 1'b1;
                        state_d = RUN;
                    end
                end
                FLUSH: begin
                    if (!memBusy_M) begin
                        {pcWrtEn, fdWrtEn, deWrtEn} = 3'b111;
                        {fdNoop, deNoop}            = 2'b11;
                        state_d                     = RUN;
                    end
                end
                MEMWAIT: begin
                    if (!memBusy_M) begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign state = state_q;

    sat_counter #(.WIDTH(CNTBITS)) u_stall_cnt (
        .clk   (clk),
        .clr_n (reset),
        .inc   (~pcWrtEn),
        .count (stallCnt)
    );

    sat_counter #(.WIDTH(CNTBITS)) u_flush_cnt (
        .clk   (clk),
        .clr_n (reset),
        .inc   (flush_inc),
        .count (flushCnt)
    );

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL take parameters: REGBITS, default 4, register index width; CNTBITS, default 16, performance counter width.
REQ-002 SHALL have the ports listed below.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- src1Index_D / src2Index_D  in  REGBITS  source indices of the instruction in Decode.
- src1Used_D / src2Used_D  in  1  source actually read by the Decode instruction.
- destIndex_E  in  REGBITS  destination index of the instruction in Execute.
- regWrtEn_E, memRead_E, noop_E  in  1  Execute instruction writes reg / is a load / is a bubble.
- redirect_E  in  1  Execute resolved a taken branch/jump (PC redirect).
- memBusy_M  in  1  data memory not ready; pipeline must freeze.
- pcWrtEn, fdWrtEn, deWrtEn  out  1  write enables for PC, FD buffer and DE buffer.
- fdNoop, deNoop  out  1  bubble flag written into FD / DE (drives noop_D).
- state  out  2  current FSM state, for debug.
- stallCnt, flushCnt  out  CNTBITS  saturating performance counters.

Function
REQ-003 SHALL implement FSM states RUN, LDSTALL, FLUSH, MEMWAIT; all outputs are combinational from state and inputs; state and counters are registered.
REQ-004 loadUse = memRead_E & regWrtEn_E & !noop_E & ((src1Used_D & src1Index_D==destIndex_E) | (src2Used_D & src2Index_D==destIndex_E)); index 0 not exempt.
REQ-005 Priority in every state: memBusy_M > redirect_E > loadUse > normal.
REQ-006 Any state with memBusy_M=1: pcWrtEn=fdWrtEn=deWrtEn=0; RUN goes to MEMWAIT; LDSTALL/FLUSH hold state.
REQ-007 MEMWAIT: all enables 0, fdNoop=deNoop=0; go to RUN the cycle after memBusy_M=0 (one-cycle resume penalty).
REQ-008 RUN, redirect_E & !noop_E: pcWrtEn=fdWrtEn=deWrtEn=1, fdNoop=deNoop=1; next FLUSH; flushCnt increments.
REQ-009 FLUSH (fixed 1 cycle, covers registered instruction-memory read): pcWrtEn=fdWrtEn=deWrtEn=1, fdNoop=deNoop=1; next RUN; redirect_E ignored.
REQ-010 RUN, loadUse: pcWrtEn=fdWrtEn=0, deWrtEn=1, deNoop=1; next LDSTALL.
REQ-011 LDSTALL (second mandatory bubble): same outputs as REQ-010, independent of loadUse; next RUN; redirect_E ignored.
REQ-012 RUN, no event: all enables 1, fdNoop=deNoop=0; stay RUN.
REQ-013 stallCnt increments each non-reset cycle with pcWrtEn=0; both counters saturate at all-ones, never wrap.

Reset
REQ-014 reset=0 SHALL immediately force state=RUN, stallCnt=flushCnt=0, independent of clk, including mid-LDSTALL/FLUSH/MEMWAIT.
REQ-015 While reset=0, outputs SHALL be pcWrtEn=fdWrtEn=deWrtEn=0, fdNoop=deNoop=1; normal operation from first rising clk edge after release.

Structure
REQ-016 Package pipe_ctrl_pkg SHALL hold the state encoding (RUN=0, LDSTALL=1, FLUSH=2, MEMWAIT=3) and default REGBITS/CNTBITS.
REQ-017 Counters SHALL use one sub-module sat_counter (parameterised width, inc, async active-low clear), instantiated twice.

Verification
REQ-018 Load r3 in E (memRead_E=1, regWrtEn_E=1, destIndex_E=3), D reads r3 via src2 -> 2 cycles pcWrtEn=0, deNoop=1, states RUN->LDSTALL->RUN, stallCnt=2.
REQ-019 redirect_E=1 for one cycle in RUN -> 2 cycles fdNoop=deNoop=1 with pcWrtEn=1, RUN->FLUSH->RUN, flushCnt=1; redirect_E=1 with noop_E=1 -> no flush.
REQ-020 memBusy_M=1 for 3 cycles in RUN -> 4 cycles all enables 0 (MEMWAIT + resume), stallCnt=4; memBusy_M during LDSTALL -> LDSTALL held, still 2 bubbles total.
REQ-021 Simultaneous redirect_E and loadUse -> flush path taken, no LDSTALL; simultaneous memBusy_M and redirect_E -> freeze, flushCnt unchanged.
REQ-022 Preload stallCnt near 0xFFFF via long memBusy_M -> holds 0xFFFF; reset=0 mid-FLUSH asynchronously -> state=RUN, counters 0, deNoop=1 before next clk edge.
